// File: rtl/qed_pkg.sv
// Shared types and default sizing for the SQED issue sequencer and register-remap block.
package qed_pkg;

  typedef enum logic {
    QED_ORIG = 1'b0,
    QED_DUP  = 1'b1
  } qed_state_e;

  localparam int QED_DEPTH  = 16;
  localparam int QED_INSN_W = 32;
  localparam int QED_CNT_W  = 16;

endpackage

// File: rtl/qed_insn_queue.sv
// Circular instruction buffer recording originals for later replay as duplicates.
module qed_insn_queue
  import qed_pkg::*;
#(
  parameter int DEPTH  = QED_DEPTH,
  parameter int INSN_W = QED_INSN_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              i_push,
  input  logic [INSN_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [INSN_W-1:0] o_head_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_occ
);

  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [INSN_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [AW:0]       r_occ;
  logic              w_push;
  logic              w_pop;

  assign o_full      = (r_occ == OCC_FULL);
  assign o_empty     = (r_occ == '0);
  assign o_occ       = r_occ;
  assign o_head_data = r_mem[r_head];

  // Guard locally so a misbehaving caller cannot corrupt the occupancy count.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= r_tail + PTR_ONE;
      end
      if (w_pop) r_head <= r_head + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/qed_issue_sequencer.sv
// Issues fetched originals straight to decode while recording them, then replays them as duplicates.
module qed_issue_sequencer
  import qed_pkg::*;
#(
  parameter int DEPTH  = QED_DEPTH,
  parameter int INSN_W = QED_INSN_W,
  parameter int CNT_W  = QED_CNT_W
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              exec_dup_i,
  input  logic              if_valid_i,
  input  logic [INSN_W-1:0] if_insn_i,
  output logic              if_ready_o,
  output logic              id_valid_o,
  output logic [INSN_W-1:0] id_insn_o,
  output logic              id_is_dup_o,
  input  logic              id_ready_i,
  input  logic              commit_valid_i,
  input  logic              commit_is_dup_i,
  output logic [CNT_W-1:0]  qed_num_orig_o,
  output logic [CNT_W-1:0]  qed_num_dup_o,
  output logic              qed_ready_o,
  output logic              state_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  qed_state_e        r_state;
  logic [CNT_W-1:0]  r_num_orig;
  logic [CNT_W-1:0]  r_num_dup;
  logic              w_is_orig;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_occ;
  logic [AW:0]       w_occ_post;
  logic [INSN_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;

  qed_insn_queue #(
    .DEPTH  (DEPTH),
    .INSN_W (INSN_W)
  ) u_queue (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_push_data (if_insn_i),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occ       (w_occ)
  );

  assign w_is_orig = (r_state == QED_ORIG);

  always_comb begin
    if_ready_o  = 1'b0;
    id_valid_o  = 1'b0;
    id_insn_o   = if_insn_i;
    id_is_dup_o = 1'b0;
    if (w_is_orig) begin
      id_valid_o = if_valid_i & ~w_full;
      if_ready_o = id_ready_i & ~w_full;
    end else begin
      id_valid_o  = ~w_empty;
      id_insn_o   = w_head;
      id_is_dup_o = 1'b1;
    end
  end

  assign w_push     = w_is_orig & if_valid_i & if_ready_o;
  assign w_pop      = ~w_is_orig & id_valid_o & id_ready_i;
  assign w_occ_post = w_occ + (w_push ? OCC_ONE : '0);

  // The switch looks at post-push occupancy so a same-cycle handshake joins the replay.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state <= QED_ORIG;
    end else begin
      case (r_state)
        QED_ORIG: if (w_occ_post != '0 && (exec_dup_i || w_occ_post == OCC_FULL))
                    r_state <= QED_DUP;
        QED_DUP:  if (w_pop && w_occ == OCC_ONE)
                    r_state <= QED_ORIG;
        default:  r_state <= QED_ORIG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_num_orig <= '0;
      r_num_dup  <= '0;
    end else if (commit_valid_i) begin
      if (!commit_is_dup_i) begin
        if (r_num_orig != '1) r_num_orig <= r_num_orig + CNT_ONE;
      end else begin
        if (r_num_dup != '1) r_num_dup <= r_num_dup + CNT_ONE;
      end
    end
  end

  assign qed_num_orig_o = r_num_orig;
  assign qed_num_dup_o  = r_num_dup;
  assign state_o        = r_state;
  assign qed_ready_o    = (r_num_orig == r_num_dup) & (r_num_orig != '0) & w_is_orig & w_empty;

endmodule
